// File: rtl/adder_bist_pkg.sv
// Shared types and helpers for the adder self-test engine.
// Holds the sweep FSM state encoding, the vector-width function and
// field extractors for the {a, b, cin} vector layout (cin is the LSB).
package adder_bist_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_APPLY = 2'd1,
        ST_CHECK = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

    function automatic int vec_w(input int width);
        return 2 * width + 1;
    endfunction

    // Extractors work on a zero-extended 64-bit copy of the vector so one
    // definition serves every WIDTH; callers cast the result to WIDTH bits.
    function automatic logic [31:0] vec_a(input logic [63:0] v, input int width);
        return 32'((v >> (width + 1)) & ((64'd1 << width) - 64'd1));
    endfunction

    function automatic logic [31:0] vec_b(input logic [63:0] v, input int width);
        return 32'((v >> 1) & ((64'd1 << width) - 64'd1));
    endfunction

    function automatic logic vec_cin(input logic [63:0] v);
        return v[0];
    endfunction

endpackage

// File: rtl/adder_bist_ref.sv
// Golden adder for the self-test engine.
// Ports:
//   a, b    - WIDTH-bit operands
//   cin     - carry-in
//   exp_sum - WIDTH+1-bit expected {carry_out, sum}
module adder_bist_ref #(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic [WIDTH:0]   exp_sum
);

    assign exp_sum = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, cin};

endmodule

// File: rtl/adder_bist_checker.sv
// Self-test engine for a WIDTH-bit ripple adder. Sweeps every {a, b, cin}
// combination, holds each for SETTLE cycles, then compares the adder result
// against a golden sum and records the error count and first failing vector.
// Ports:
//   clk, rst_n            - clock, synchronous active-low reset
//   start                 - sweep request (accepted in IDLE or DONE only)
//   busy, done, pass      - sweep status; pass valid while done
//   err_count             - mismatching vectors in current/last sweep
//   first_fail_vec        - {a, b, cin} of the first mismatch, zero if none
//   dut_a, dut_b, dut_cin - stimulus to the adder under test
//   dut_sum, dut_cout     - response from the adder under test
//
// state  | meaning
// -------+-----------------------------------------------------------
// IDLE   | waiting for start after reset
// APPLY  | current vector driven, settle timer counting down
// CHECK  | adder output compared, vector advanced or sweep finished
// DONE   | results held, dut_* keep the last vector, start reruns
module adder_bist_checker
    import adder_bist_pkg::*;
#(
    parameter int WIDTH  = 4,
    parameter int SETTLE = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    output logic                 busy,
    output logic                 done,
    output logic                 pass,
    output logic [2*WIDTH+1:0]   err_count,
    output logic [2*WIDTH:0]     first_fail_vec,
    output logic [WIDTH-1:0]     dut_a,
    output logic [WIDTH-1:0]     dut_b,
    output logic                 dut_cin,
    input  logic [WIDTH-1:0]     dut_sum,
    input  logic                 dut_cout
);

    localparam int VW = vec_w(WIDTH);
    localparam int EW = VW + 1;
    localparam int SW = (SETTLE > 1) ? $clog2(SETTLE) : 1;

    localparam logic [SW-1:0] SETTLE_LOAD = SW'(SETTLE - 1);
    localparam logic [SW-1:0] SETTLE_ONE  = SW'(1);
    localparam logic [VW-1:0] VEC_LAST    = '1;
    localparam logic [VW-1:0] VEC_ONE     = VW'(1);
    localparam logic [EW-1:0] ERR_ONE     = EW'(1);

    state_e          state_q, state_d;
    logic [VW-1:0]   vec_q, vec_d;
    logic [SW-1:0]   settle_q, settle_d;
    logic [EW-1:0]   err_count_q, err_count_d;
    logic [VW-1:0]   first_fail_q, first_fail_d;
    logic            fail_seen_q, fail_seen_d;

    logic [WIDTH:0]  exp_sum;
    logic            mismatch;

    // Stimulus comes straight from the registered vector counter, so it is
    // stable for the whole APPLY+CHECK window and zero out of reset.
    assign dut_a   = WIDTH'(vec_a(64'(vec_q), WIDTH));
    assign dut_b   = WIDTH'(vec_b(64'(vec_q), WIDTH));
    assign dut_cin = vec_cin(64'(vec_q));

    adder_bist_ref #(
        .WIDTH (WIDTH)
    ) u_ref (
        .a       (dut_a),
        .b       (dut_b),
        .cin     (dut_cin),
        .exp_sum (exp_sum)
    );

    assign mismatch = ({dut_cout, dut_sum} != exp_sum);

    always_comb begin
        state_d      = state_q;
        vec_d        = vec_q;
        settle_d     = settle_q;
        err_count_d  = err_count_q;
        first_fail_d = first_fail_q;
        fail_seen_d  = fail_seen_q;

        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    state_d      = ST_APPLY;
                    vec_d        = '0;
                    settle_d     = SETTLE_LOAD;
                    err_count_d  = '0;
                    first_fail_d = '0;
                    fail_seen_d  = 1'b0;
                end
            end
            ST_APPLY: begin
                if (settle_q == '0) begin
                    state_d = ST_CHECK;
                end else begin
                    settle_d = settle_q - SETTLE_ONE;
                end
            end
            ST_CHECK: begin
                if (mismatch) begin
                    err_count_d = err_count_q + ERR_ONE;
                    if (!fail_seen_q) begin
                        first_fail_d = vec_q;
                        fail_seen_d  = 1'b1;
                    end
                end
                if (vec_q == VEC_LAST) begin
                    state_d = ST_DONE;
                end else begin
                    vec_d    = vec_q + VEC_ONE;
                    settle_d = SETTLE_LOAD;
                    state_d  = ST_APPLY;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            vec_q        <= '0;
            settle_q     <= '0;
            err_count_q  <= '0;
            first_fail_q <= '0;
            fail_seen_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            vec_q        <= vec_d;
            settle_q     <= settle_d;
            err_count_q  <= err_count_d;
            first_fail_q <= first_fail_d;
            fail_seen_q  <= fail_seen_d;
        end
    end

    assign busy           = (state_q == ST_APPLY) || (state_q == ST_CHECK);
    assign done           = (state_q == ST_DONE);
    assign pass           = (state_q == ST_DONE) && (err_count_q == '0);
    assign err_count      = err_count_q;
    assign first_fail_vec = first_fail_q;

endmodule

// File: doc/adder_bist_checker.md
# adder_bist_checker

Self-test engine for the `add_4_bit` adder. It is the on-chip responder to the adder's interface: it drives every `{a, b, carryIn}` combination into the adder and samples the adder's `sum`/`carryOut` after a programmable settle time. Each result is compared against an internal golden sum. The block reports busy/done/pass, an error count, and the first failing vector, and sits beside the adder instance as its production self-check.

## Interface
- `WIDTH`, default 4: operand width of the adder under test.
- `SETTLE`, default 1: cycles a vector is held before sampling. Legal range is 1 or more.
- `clk` input, 1 bit: single clock, rising edge.
- `rst_n` input, 1 bit: reset, synchronous and active-low.
- `start` input, 1 bit: one-cycle request to begin a sweep. Ignored while `busy`.
- `busy` output, 1 bit: high while a sweep is in progress.
- `done` output, 1 bit: high from sweep completion until the next accepted `start` or reset.
- `pass` output, 1 bit: valid when `done`. High only if no mismatch occurred.
- `err_count` output, 2·WIDTH+2 bits: number of mismatching vectors in the current or last sweep.
- `first_fail_vec` output, 2·WIDTH+1 bits: `{a, b, cin}` of the first mismatch. Zero if none.
- `dut_a`, `dut_b` outputs, WIDTH bits each: operands driven to the adder.
- `dut_cin` output, 1 bit: carry-in driven to the adder.
- `dut_sum` input, WIDTH bits: adder sum.
- `dut_cout` input, 1 bit: adder carry-out.

## Operation
- Vector counter `vec` is 2·WIDTH+1 bits, laid out `{a, b, cin}` with `cin` as the LSB. The sweep runs `vec` from 0 to 2^(2·WIDTH+1)−1, which is 512 vectors for WIDTH=4. Order: `a` outermost, `b` next, `cin` innermost.
- Expected value is `a + b + cin`, computed at WIDTH+1 bits. A mismatch is any difference between `{dut_cout, dut_sum}` and the expected value.
- States:
  - **IDLE**: `start` moves to APPLY. `vec`, `err_count`, `first_fail_vec` and the internal `fail_seen` flag clear. `done` and `pass` drop.
  - **APPLY**: `dut_*` hold `vec`. A settle counter runs for SETTLE cycles, then the block moves to CHECK.
  - **CHECK**: compare, then increment `err_count` on a mismatch. On the first mismatch, capture `first_fail_vec` and set `fail_seen`. If `vec` is the last vector, go to DONE; otherwise increment `vec` and go to APPLY.
  - **DONE**: `done` = 1 and `pass` = (`err_count` == 0). `dut_*` keep the last vector. `start` restarts exactly as from IDLE.
- `err_count` width holds the full vector count, so it never overflows and needs no saturation.
- `start` is accepted only in IDLE or DONE. A `start` in APPLY or CHECK has no effect.

## Timing
- Reset (`rst_n` = 0 at an edge) puts every output at 0 on that edge: `busy`, `done`, `pass`, `err_count`, `first_fail_vec`, `dut_a`, `dut_b`, `dut_cin`. State returns to IDLE.
- Reset mid-sweep abandons the sweep with no partial report, and the block waits for a new `start`.
- `busy` rises on the edge that samples `start`. On that same edge, `dut_*` = 0 and state = APPLY.
- Each vector occupies SETTLE+1 cycles: SETTLE in APPLY plus 1 in CHECK. `dut_*` are registered and stable across that whole window.
- `dut_sum`/`dut_cout` are sampled at the CHECK edge, so the adder gets at least SETTLE full cycles of combinational settle.
- Full sweep: `done` rises 512·(SETTLE+1) cycles after the `start` edge, which is 1024 cycles at SETTLE=1. `busy` falls on the same edge.
- `err_count` and `first_fail_vec` update on the CHECK edge and are final when `done` rises.

## Structure
- Package `adder_bist_pkg` holds:
  - the state enum (IDLE, APPLY, CHECK, DONE);
  - a `vec_w(WIDTH)` = 2·WIDTH+1 constant function;
  - field-slice helpers for the `{a, b, cin}` layout.
- One sub-module, `adder_bist_ref`: the combinational golden adder, WIDTH-parameterised, producing a WIDTH+1-bit expected value.
- The FSM, counters and capture logic live in `adder_bist_checker`.

## Test plan
- **Correct adder, SETTLE=1.** Pulse `start` → `busy` high the next cycle. After 1024 cycles, `done` = 1, `pass` = 1, `err_count` = 0, `first_fail_vec` = 0.
- **Sum bit 0 stuck at 0.** → `err_count` = 256, `pass` = 0, `first_fail_vec` = 9'h001 (a=0, b=0, cin=1).
- **carryOut stuck at 0.** → `err_count` = 256 (120 vectors with a+b ≥ 16 plus 136 with a+b ≥ 15 and cin=1), `first_fail_vec` = 9'h01F (a=0, b=15, cin=1).
- **Reset mid-sweep.** Drop `rst_n` for one cycle during vector 100 → all outputs 0 on the following edge, and the block stays idle. A new `start` then completes a clean sweep with `pass` = 1.
- **Start handling.** A `start` pulsed at vector 50 is ignored, and completion timing is unchanged. A `start` in DONE after a faulty sweep clears `err_count`, `first_fail_vec` and `done` on the next edge, and the rerun against a correct adder gives `pass` = 1.
- **SETTLE=3 with a 2-cycle-delayed adder model.** → `pass` = 1 and `done` at 2048 cycles.
